// File: rtl/moving_sum_pkg.sv
// Shared DSP types for the power/energy path: sample word, accumulator
// width helper and the window fill state.
package moving_sum_pkg;

  // Default power word width out of the magnitude-squared stage.
  localparam int unsigned PWR_W = 32;

  typedef logic [PWR_W-1:0] pwr_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_e;

  // Width that holds the sum of len unsigned w-bit samples without wrap.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned len);
    return w + $clog2(len + 1);
  endfunction

endpackage

// File: rtl/moving_sum_if.sv
// Valid/ready stream pair around the moving sum: power samples in,
// windowed sums out.
interface moving_sum_if
  import moving_sum_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 16
) ();

  localparam int unsigned OUT_WIDTH = acc_width(WIDTH, LENGTH);

  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH-1:0]     s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_full;

  // Block side.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_full
  );

  // Upstream/downstream side.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_full
  );

endinterface

// File: rtl/moving_sum_sample_ring.sv
// LENGTH x WIDTH circular delay line. rd_old is the entry at the write
// pointer, i.e. the sample written LENGTH writes ago; it is read in the
// same cycle that the new sample overwrites it.
module sample_ring #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_old
);

  localparam int unsigned PTR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  logic [WIDTH-1:0] mem [LENGTH];
  logic [PTR_W-1:0] wr_ptr;

  assign rd_old = mem[wr_ptr];

  // Write pointer advances per write and wraps at LENGTH-1 (non power of two ok).
  always_ff @(posedge clk) begin
    if (reset)
      wr_ptr <= '0;
    else if (wr_en)
      wr_ptr <= (wr_ptr == PTR_W'(LENGTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
  end

  // Storage is never cleared; consumers mask stale entries themselves.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/moving_sum.sv
// Sliding-window power accumulator: m_data is the sum of the last LENGTH
// accepted samples, one output register, 1-cycle latency, no skid buffer.
module moving_sum
  import moving_sum_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  moving_sum_if.slave  bus
);

  localparam int unsigned OUT_WIDTH = acc_width(WIDTH, LENGTH);
  localparam int unsigned CNT_W     = $clog2(LENGTH + 1);

  win_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q;
  logic [OUT_WIDTH-1:0] sum_q, sum_next;
  logic [WIDTH-1:0]     ring_old, old;
  logic                 load, accept;
  logic                 m_valid_q, m_full_q;
  logic [OUT_WIDTH-1:0] m_data_q;

  // Output register is free when empty or being drained this cycle.
  assign load         = !m_valid_q || bus.m_ready;
  assign bus.s_ready  = load;
  assign accept       = bus.s_valid && load;

  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_full   = m_full_q;

  sample_ring #(
    .WIDTH  (WIDTH),
    .LENGTH (LENGTH)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept && !reset),
    .wr_data (bus.s_data),
    .rd_old  (ring_old)
  );

  // Fill tracking: mask the departing sample until LENGTH samples are in.
  always_comb begin
    state_d = state_q;
    old     = ring_old;
    if (state_q == FILL) begin
      old = '0;
      if (accept && count_q == CNT_W'(LENGTH - 1))
        state_d = RUN;
    end
  end

  // Sum never exceeds LENGTH * (2^WIDTH - 1), so OUT_WIDTH cannot wrap.
  assign sum_next = sum_q + OUT_WIDTH'(bus.s_data) - OUT_WIDTH'(old);

  // Fill state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Accepted-sample count, only meaningful while filling.
  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else if (accept && state_q == FILL)
      count_q <= count_q + CNT_W'(1);
  end

  // Running window sum.
  always_ff @(posedge clk) begin
    if (reset)
      sum_q <= '0;
    else if (accept)
      sum_q <= sum_next;
  end

  // Output register: refilled or emptied whenever it is free, held on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_full_q  <= 1'b0;
    end else if (load) begin
      m_valid_q <= accept;
      if (accept) begin
        m_data_q <= sum_next;
        m_full_q <= (state_d == RUN);
      end
    end
  end

endmodule

// File: tb/tb_moving_sum.sv
// Bench for moving_sum: a LENGTH=4 and a LENGTH=1 build driven in lockstep
// and compared against a window-sum model over the accepted-sample history.
module tb_moving_sum;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  moving_sum_if #(.WIDTH(8), .LENGTH(4)) bus4 ();
  moving_sum_if #(.WIDTH(8), .LENGTH(1)) bus1 ();

  moving_sum #(.WIDTH(8), .LENGTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  moving_sum #(.WIDTH(8), .LENGTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: history of accepted samples plus expected output register contents.
  int unsigned hist[$];
  logic        mv;
  int unsigned d4, d1;
  logic        f4, f1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check what the last edge produced, then advance
  // the model for the coming edge.
  task automatic step(input logic rst, input logic sv, input logic [7:0] sd, input logic mr);
    @(negedge clk);
    reset        = rst;
    bus4.s_valid = sv;  bus1.s_valid = sv;
    bus4.s_data  = sd;  bus1.s_data  = sd;
    bus4.m_ready = mr;  bus1.m_ready = mr;
    #1;
    chk("m_valid4", 32'(bus4.m_valid), 32'(mv));
    chk("m_valid1", 32'(bus1.m_valid), 32'(mv));
    chk("s_ready4", 32'(bus4.s_ready), 32'(!mv || mr));
    chk("s_ready1", 32'(bus1.s_ready), 32'(!mv || mr));
    chk("m_data4",  32'(bus4.m_data),  d4);
    chk("m_full4",  32'(bus4.m_full),  32'(f4));
    chk("m_data1",  32'(bus1.m_data),  d1);
    chk("m_full1",  32'(bus1.m_full),  32'(f1));
    if (rst) begin
      mv = 1'b0; d4 = 0; d1 = 0; f4 = 1'b0; f1 = 1'b0;
      hist.delete();
    end else if (!mv || mr) begin
      mv = sv;
      if (sv) begin
        hist.push_back(32'(sd));
        d4 = 0;
        for (int i = 0; i < 4 && i < hist.size(); i++)
          d4 += hist[hist.size() - 1 - i];
        f4 = (hist.size() >= 4);
        d1 = 32'(sd);
        f1 = 1'b1;
        if (hist.size() > 8) void'(hist.pop_front());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus4.s_valid = 1'b0; bus1.s_valid = 1'b0;
    bus4.s_data  = '0;   bus1.s_data  = '0;
    bus4.m_ready = 1'b1; bus1.m_ready = 1'b1;
    mv = 1'b0; d4 = 0; d1 = 0; f4 = 1'b0; f1 = 1'b0;
    repeat (2) @(posedge clk);

    // Back-to-back 1..6: sums 1,3,6,10,14,18.
    for (int v = 1; v <= 6; v++) step(1'b0, 1'b1, 8'(v), 1'b1);
    repeat (2) step(1'b0, 1'b0, 8'd0, 1'b1);

    // Stall after the 2nd output with 3 pending, then release.
    step(1'b1, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b1, 8'd1, 1'b1);
    step(1'b0, 1'b1, 8'd2, 1'b1);
    repeat (5) step(1'b0, 1'b1, 8'd3, 1'b0);
    step(1'b0, 1'b1, 8'd3, 1'b1);
    step(1'b0, 1'b1, 8'd4, 1'b1);
    repeat (2) step(1'b0, 1'b0, 8'd0, 1'b1);

    // Saturating input: 255 x10, window tops out at 1020.
    step(1'b1, 1'b0, 8'd0, 1'b1);
    repeat (10) step(1'b0, 1'b1, 8'd255, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);

    // Mid-stream reset drops the sample offered with it.
    step(1'b1, 1'b0, 8'd0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 8'd9, 1'b1);
    step(1'b1, 1'b1, 8'd9, 1'b1);
    step(1'b0, 1'b1, 8'd7, 1'b1);
    repeat (2) step(1'b0, 1'b0, 8'd0, 1'b1);

    // Idle gaps must not advance the window.
    step(1'b1, 1'b0, 8'd0, 1'b1);
    for (int v = 1; v <= 5; v++) begin
      step(1'b0, 1'b1, 8'(v), 1'b1);
      repeat (3) step(1'b0, 1'b0, 8'd0, 1'b1);
    end

    // LENGTH=1 pattern 5,200,0 (also exercises the LENGTH=4 build).
    step(1'b1, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b1, 8'd5, 1'b1);
    step(1'b0, 1'b1, 8'd200, 1'b1);
    step(1'b0, 1'b1, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);

    // Random traffic with back-pressure and occasional reset.
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 80) == 0, ($urandom % 4) != 0,
           8'($urandom), ($urandom % 3) != 0);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
